// File: rtl/exec_trace_monitor_pkg.sv
// Shared halt-cause and trace-kind codes, record layout and halt priority helper
// for the commit-side execution monitor.
package exec_trace_monitor_pkg;

  typedef enum logic [1:0] {
    HALT_NONE  = 2'd0,
    HALT_LOOP  = 2'd1,
    HALT_ZERO  = 2'd2,
    HALT_PCLIM = 2'd3
  } halt_cause_t;

  typedef enum logic [1:0] {
    TR_NONE  = 2'd0,
    TR_REG   = 2'd1,
    TR_STORE = 2'd2
  } tr_kind_t;

  // beq x0,x0,0: the conventional "spin here forever" end-of-program marker
  localparam logic [31:0] INSTR_SELF_LOOP = 32'h00000063;

  localparam int REC_XLEN = 32;

  typedef struct packed {
    tr_kind_t            kind;
    logic [REC_XLEN-1:0] pc;
    logic [REC_XLEN-1:0] addr;
    logic [REC_XLEN-1:0] data;
  } trace_rec_t;

  function automatic halt_cause_t halt_check(input logic [31:0] instr,
                                             input logic        pc_over,
                                             input logic        zero_en);
    halt_cause_t c;
    c = HALT_NONE;
    if (instr == INSTR_SELF_LOOP)       c = HALT_LOOP;
    else if (zero_en && instr == 32'd0) c = HALT_ZERO;
    else if (pc_over)                   c = HALT_PCLIM;
    return c;
  endfunction

endpackage

// File: rtl/exec_trace_monitor_trace_fifo.sv
// Synchronous record FIFO: push/full on the write side, valid/ready on the read side.
// Head is read straight out of storage and forced to zero while empty.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop;
  logic             do_push;

  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = valid && ready;
  // a same-edge pop frees the slot, so a full FIFO can still take the push
  assign do_push = push && (!full || pop);
  assign dout    = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/exec_trace_monitor.sv
// Commit-side execution monitor: cycle/retire/store/drop counters, sticky halt
// detection, and a trace FIFO of register-write and store records.
module exec_trace_monitor
  import exec_trace_monitor_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter int               CNT_W        = 32,
  parameter int               DEPTH        = 8,
  parameter logic [XLEN-1:0]  PC_LIMIT     = 'h200,
  parameter bit               HALT_ON_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             retire,
  input  logic [XLEN-1:0]  pc,
  input  logic [31:0]      instr,
  input  logic             reg_write,
  input  logic [4:0]       rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             mem_write,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] store_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [1:0]       trace_kind,
  output logic [XLEN-1:0]  trace_pc,
  output logic [XLEN-1:0]  trace_addr,
  output logic [XLEN-1:0]  trace_data
);

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    tr_kind_t        kind;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } rec_t;

  state_t      state;
  rec_t        rec;
  rec_t        head;
  logic        active, is_store, is_reg, push, pop, fifo_full;
  logic        lost_both, lost_full;
  logic [1:0]  n_lost;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_next;
  halt_cause_t cause;

  assign active    = (state == RUN) && retire;
  assign is_store  = active && mem_write;
  assign is_reg    = active && reg_write && (rd != 5'd0);
  assign push      = (is_store || is_reg) && !clr;
  assign pop       = trace_valid && trace_ready;
  assign lost_both = is_store && is_reg;
  assign lost_full = push && fifo_full && !pop;
  assign cause     = halt_check(instr, pc >= PC_LIMIT, HALT_ON_ZERO);

  // a retire can lose two records at once: the shadowed reg write and the store itself
  assign n_lost    = {1'b0, lost_both} + {1'b0, lost_full};
  assign drop_sum  = {1'b0, drop_cnt} + (CNT_W+1)'(n_lost);
  assign drop_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

  always_comb begin
    rec      = '0;
    rec.kind = is_store ? TR_STORE : TR_REG;
    rec.pc   = pc;
    rec.addr = is_store ? mem_addr : XLEN'(rd);
    rec.data = is_store ? mem_wdata : wb_data;
  end

  trace_fifo #(
    .WIDTH($bits(rec_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .din   (rec),
    .full  (fifo_full),
    .valid (trace_valid),
    .ready (trace_ready),
    .dout  (head)
  );

  assign trace_kind = head.kind;
  assign trace_pc   = head.pc;
  assign trace_addr = head.addr;
  assign trace_data = head.data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      halted     <= 1'b0;
      halt_cause <= HALT_NONE;
      cycle_cnt  <= '0;
      instret    <= '0;
      store_cnt  <= '0;
      drop_cnt   <= '0;
    end else if (clr) begin
      state      <= RUN;
      halted     <= 1'b0;
      halt_cause <= HALT_NONE;
      cycle_cnt  <= '0;
      instret    <= '0;
      store_cnt  <= '0;
      drop_cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          drop_cnt  <= drop_next;
          if (retire) begin
            instret <= instret + 1'b1;
            if (mem_write) store_cnt <= store_cnt + 1'b1;
            if (cause != HALT_NONE) begin
              state      <= HALTED;
              halted     <= 1'b1;
              halt_cause <= cause;
            end
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_trace_monitor.sv
// Directed and randomized bench for exec_trace_monitor against a queue-based reference model.
module tb_exec_trace_monitor;
  import exec_trace_monitor_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, clr, retire, reg_write, mem_write, trace_ready;
  logic [31:0] pc, instr, wb_data, mem_addr, mem_wdata;
  logic [4:0]  rd;

  logic        halted, trace_valid;
  logic [1:0]  halt_cause, trace_kind;
  logic [31:0] cycle_cnt, instret, store_cnt, drop_cnt, trace_pc, trace_addr, trace_data;

  logic        nz_halted, nz_valid;
  logic [1:0]  nz_cause, nz_kind;
  logic [31:0] nz_cycle, nz_instret, nz_store, nz_drop, nz_pc, nz_addr, nz_data;

  exec_trace_monitor dut (
    .clk(clk), .rst(rst), .clr(clr), .retire(retire), .pc(pc), .instr(instr),
    .reg_write(reg_write), .rd(rd), .wb_data(wb_data), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .halted(halted), .halt_cause(halt_cause),
    .cycle_cnt(cycle_cnt), .instret(instret), .store_cnt(store_cnt), .drop_cnt(drop_cnt),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_kind(trace_kind),
    .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data)
  );

  exec_trace_monitor #(.HALT_ON_ZERO(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .clr(clr), .retire(retire), .pc(pc), .instr(instr),
    .reg_write(reg_write), .rd(rd), .wb_data(wb_data), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .halted(nz_halted), .halt_cause(nz_cause),
    .cycle_cnt(nz_cycle), .instret(nz_instret), .store_cnt(nz_store), .drop_cnt(nz_drop),
    .trace_valid(nz_valid), .trace_ready(trace_ready), .trace_kind(nz_kind),
    .trace_pc(nz_pc), .trace_addr(nz_addr), .trace_data(nz_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] pc, addr, data;
  } mrec_t;

  mrec_t       q[$];
  logic [31:0] m_cycle, m_instret, m_store, m_drop;
  bit          m_halted;
  logic [1:0]  m_cause;

  function automatic logic [1:0] model_cause(logic [31:0] i, logic [31:0] p, bit hoz);
    if (i == 32'h00000063) return 2'd1;
    if (hoz && i == 32'd0) return 2'd2;
    if (p >= 32'h200)      return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cycle = 0; m_instret = 0; m_store = 0; m_drop = 0;
    m_halted = 0; m_cause = 0;
  endtask

  task automatic model_edge();
    bit pop, have;
    mrec_t r;
    int lost;
    longint s;
    logic [1:0] c;
    if (clr) begin
      model_reset();
      return;
    end
    pop = (q.size() > 0) && trace_ready;
    have = 0;
    lost = 0;
    r = '{kind: 2'd0, pc: 32'd0, addr: 32'd0, data: 32'd0};
    if (!m_halted) begin
      m_cycle = m_cycle + 1;
      if (retire) begin
        m_instret = m_instret + 1;
        if (mem_write) begin
          m_store = m_store + 1;
          r = '{kind: 2'd2, pc: pc, addr: mem_addr, data: mem_wdata};
          have = 1;
          if (reg_write && rd != 0) lost++;
        end else if (reg_write && rd != 0) begin
          r = '{kind: 2'd1, pc: pc, addr: {27'd0, rd}, data: wb_data};
          have = 1;
        end
        c = model_cause(instr, pc, 1'b1);
        if (c != 0) begin
          m_halted = 1;
          m_cause  = c;
        end
      end
    end
    if (pop) void'(q.pop_front());
    if (have) begin
      if (q.size() < DEPTH) q.push_back(r);
      else lost++;
    end
    s = longint'(m_drop) + lost;
    m_drop = (s > 64'h00000000FFFFFFFF) ? 32'hFFFFFFFF : s[31:0];
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    mrec_t h;
    h = '{kind: 2'd0, pc: 32'd0, addr: 32'd0, data: 32'd0};
    if (q.size() > 0) h = q[0];
    chk({tag, ".halted"},     32'(halted),      32'(m_halted));
    chk({tag, ".cause"},      32'(halt_cause),  32'(m_cause));
    chk({tag, ".cycle"},      cycle_cnt,        m_cycle);
    chk({tag, ".instret"},    instret,          m_instret);
    chk({tag, ".store"},      store_cnt,        m_store);
    chk({tag, ".drop"},       drop_cnt,         m_drop);
    chk({tag, ".valid"},      32'(trace_valid), 32'(q.size() > 0));
    chk({tag, ".kind"},       32'(trace_kind),  32'(h.kind));
    chk({tag, ".tpc"},        trace_pc,         h.pc);
    chk({tag, ".taddr"},      trace_addr,       h.addr);
    chk({tag, ".tdata"},      trace_data,       h.data);
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(bit r, logic [31:0] p, logic [31:0] ins, bit rw, logic [4:0] d,
                       logic [31:0] wb, bit mw, logic [31:0] a, logic [31:0] wd);
    retire = r; pc = p; instr = ins; reg_write = rw; rd = d; wb_data = wb;
    mem_write = mw; mem_addr = a; mem_wdata = wd;
  endtask

  task automatic idle();
    drive(0, 32'd0, 32'h00000013, 0, 5'd0, 32'd0, 0, 32'd0, 32'd0);
  endtask

  task automatic do_clr(string tag);
    idle();
    clr = 1;
    tick(tag);
    clr = 0;
  endtask

  initial begin
    logic [31:0] rnd, ins;
    rst = 1; clr = 0; trace_ready = 0;
    idle();
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // 1: addi x5,x0,7 traced as a register write, then popped
    drive(1, 32'h0, 32'h00700293, 1, 5'd5, 32'd7, 0, 32'd0, 32'd0);
    tick("t1_push");
    chk("t1_kind", 32'(trace_kind), 32'd1);
    chk("t1_addr", trace_addr, 32'd5);
    chk("t1_data", trace_data, 32'd7);
    idle(); trace_ready = 1;
    tick("t1_pop");
    chk("t1_instret", instret, 32'd1);
    tick("t1_idle");

    // 2: store traced, rd=0 write ignored
    trace_ready = 0;
    drive(1, 32'h4, 32'h0062A023, 0, 5'd0, 32'd0, 1, 32'h40, 32'hDEAD);
    tick("t2_sw");
    drive(1, 32'h8, 32'h00000013, 1, 5'd0, 32'h55, 0, 32'd0, 32'd0);
    tick("t2_x0");
    chk("t2_kind", 32'(trace_kind), 32'd2);
    chk("t2_addr", trace_addr, 32'h40);
    chk("t2_data", trace_data, 32'hDEAD);
    chk("t2_store", store_cnt, 32'd1);
    idle(); trace_ready = 1;
    tick("t2_pop");
    chk("t2_one", 32'(trace_valid), 32'd0);

    // 3: overflow the FIFO, then push into a full FIFO alongside a pop
    do_clr("t3_clr");
    trace_ready = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'(i * 4), 32'h00000093, 1, 5'(i + 1), $urandom, 0, 32'd0, 32'd0);
      tick("t3_fill");
    end
    chk("t3_drop", drop_cnt, 32'd2);
    trace_ready = 1;
    drive(1, 32'h100, 32'h00000093, 1, 5'd9, 32'h1234, 0, 32'd0, 32'd0);
    tick("t3_popush");
    chk("t3_drop_keep", drop_cnt, 32'd2);
    idle();
    for (int i = 0; i < 9; i++) tick("t3_drain");

    // 4: self-loop halt freezes counters, FIFO still drains
    do_clr("t4_clr");
    trace_ready = 0;
    drive(1, 32'h1C, 32'h00000063, 1, 5'd1, 32'h77, 0, 32'd0, 32'd0);
    tick("t4_halt");
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_cause", 32'(halt_cause), 32'd1);
    trace_ready = 1;
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'(4 * i), 32'h00000093, 1, 5'd3, $urandom, 1, 32'h80, $urandom);
      tick("t4_frozen");
    end
    chk("t4_instret", instret, 32'd1);
    chk("t4_cycle", cycle_cnt, 32'd1);
    chk("t4_drained", 32'(trace_valid), 32'd0);

    // 5: zero instruction outranks the PC limit unless disabled
    do_clr("t5_clr");
    drive(1, 32'h200, 32'h00000000, 0, 5'd0, 32'd0, 0, 32'd0, 32'd0);
    tick("t5_halt");
    chk("t5_cause", 32'(halt_cause), 32'd2);
    chk("t5_nz_halted", 32'(nz_halted), 32'd1);
    chk("t5_nz_cause", 32'(nz_cause), 32'd3);
    chk("t5_nz_cycle", nz_cycle, m_cycle);
    chk("t5_nz_instret", nz_instret, m_instret);
    chk("t5_nz_store", nz_store, m_store);
    chk("t5_nz_drop", nz_drop, m_drop);
    chk("t5_nz_valid", 32'(nz_valid), 32'd0);
    chk("t5_nz_trace", {30'd0, nz_kind} | nz_pc | nz_addr | nz_data, 32'd0);

    // 6: async reset mid-cycle, then the same condition cleared by clr
    for (int pass = 0; pass < 2; pass++) begin
      do_clr("t6_clr0");
      trace_ready = 0;
      for (int i = 0; i < 3; i++) begin
        drive(1, 32'(8 * i), 32'h00000093, 1, 5'(i + 2), $urandom, 0, 32'd0, 32'd0);
        tick("t6_fill");
      end
      drive(1, 32'h30, 32'h00000063, 0, 5'd0, 32'd0, 0, 32'd0, 32'd0);
      tick("t6_halt");
      chk("t6_pre_halted", 32'(halted), 32'd1);
      idle();
      if (pass == 0) begin
        #2 rst = 1;
        #1;
        model_reset();
        check_all("t6_rst");
        #1 rst = 0;
      end else begin
        clr = 1;
        tick("t6_clr");
        clr = 0;
        chk("t6_clr_valid", 32'(trace_valid), 32'd0);
      end
    end

    // randomized traffic against the model
    do_clr("rnd_clr");
    for (int n = 0; n < 600; n++) begin
      rnd = $urandom;
      ins = {rnd[31:7], 7'h13};
      if (rnd[5:0] == 6'd0)      ins = 32'h00000063;
      else if (rnd[5:0] == 6'd1) ins = 32'd0;
      drive(($urandom % 4) != 0,
            (($urandom % 40) == 0) ? 32'h200 + ($urandom % 64) : ($urandom % 128) * 4,
            ins, $urandom % 2, 5'($urandom), $urandom,
            ($urandom % 4) == 0, $urandom, $urandom);
      trace_ready = ($urandom % 3) == 0;
      clr = (m_halted && ($urandom % 10) == 0) || (($urandom % 150) == 0);
      tick("rnd");
      clr = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_trace_monitor.md
Name: exec_trace_monitor

Overview:
- Synthesisable execution monitor for the single-cycle RISC-V core. It taps the commit-side signals the core already exposes (PC, instruction, register write-back and store bus).
- Maintains cycle, retired-instruction, store and drop counters, and detects halt conditions: self-loop, zero instruction, PC beyond limit.
- Buffers architectural-effect records in a trace FIFO, drained by a valid/ready consumer such as a UART dumper or debug port.
- Parametrised in data width, counter width, trace depth and PC limit; the halt cause is reported as a code.

Parameters:
XLEN, 32, width of PC, instruction, data and address fields
CNT_W, 32, width of every counter
DEPTH, 8, trace FIFO entries (power of two, ≥2)
PC_LIMIT, 32'h200, halt when retired PC ≥ this value
HALT_ON_ZERO, 1, enable halt on instruction 32'h00000000

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
clr  in  1  synchronous clear of counters, halt and FIFO
retire  in  1  one instruction commits this cycle
pc  in  XLEN  PC of the committing instruction
instr  in  32  committing instruction word
reg_write  in  1  core RegWrite
rd  in  5  destination register
wb_data  in  XLEN  write-back Result
mem_write  in  1  core MemWrite
mem_addr  in  XLEN  store address (ALUResult)
mem_wdata  in  XLEN  store data (RD2)
halted  out  1  sticky halt flag
halt_cause  out  2  0 none, 1 self-loop, 2 zero-instr, 3 PC-limit
cycle_cnt  out  CNT_W  cycles since reset/clr while not halted
instret  out  CNT_W  retired instructions
store_cnt  out  CNT_W  retired stores
drop_cnt  out  CNT_W  trace records lost to a full FIFO (saturating)
trace_valid  out  1  FIFO head valid
trace_ready  in  1  consumer accepts head
trace_kind  out  2  1 register write, 2 store
trace_pc  out  XLEN  PC of the record
trace_addr  out  XLEN  zero-extended rd, or store address
trace_data  out  XLEN  write-back value, or store data

Behaviour:
- Reset (rst=1, asynchronous): all counters 0, halted=0, halt_cause=0, FIFO empty, trace_valid=0, trace_* = 0.
- clr=1: same state as reset at the next edge. clr takes priority over every same-cycle event, including a retire or a pop.
- States: RUN and HALTED.
- In RUN:
  - cycle_cnt increments each clock.
  - On retire, instret increments.
  - On retire & mem_write, store_cnt increments.
- Halt detection is evaluated on retire only. Priority order:
  - instr==32'h00000063 gives cause 1.
  - HALT_ON_ZERO and instr==0 gives cause 2.
  - pc ≥ PC_LIMIT (unsigned) gives cause 3.
- On a detected halt:
  - The halting instruction is still counted and still traced.
  - halted and halt_cause register at that edge, so they are visible the next cycle.
  - The machine moves to HALTED.
- In HALTED: all counters freeze and retire is ignored (no counts, no pushes). FIFO draining continues. Only rst or clr returns the machine to RUN.
- Push rules, one record per retire:
  - retire & reg_write & rd≠0 pushes kind 1 {pc, rd zero-extended, wb_data}.
  - retire & mem_write pushes kind 2 {pc, mem_addr, mem_wdata}.
  - If both apply, the store wins and drop_cnt increments.
  - Writes to rd=0 are never traced.
- Pop: trace_valid & trace_ready at the edge.
- Head outputs are registered FIFO storage. A record pushed at edge N is visible on trace_valid at N+1 when the FIFO was empty.
- Full: a push with no same-cycle pop is dropped and drop_cnt increments, saturating at all-ones. A push with a same-cycle pop when full is accepted.
- Empty: a pop while trace_valid=0 is ignored. A push and pop on an empty FIFO leaves the pushed record.
- Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH. full and empty derive from the pointer MSB comparison.
- The counters cycle_cnt, instret and store_cnt wrap modulo 2^CNT_W.

Decomposition:
- Shared package holds:
  - halt cause codes: HALT_NONE, HALT_LOOP, HALT_ZERO, HALT_PCLIM
  - trace kind codes: TR_REG, TR_STORE
  - the constant INSTR_SELF_LOOP = 32'h00000063
  - record typedef {kind, pc, addr, data}
- The existing opcode defines are reused unchanged.
- One sub-module: trace_fifo. It is a parametrised synchronous FIFO with a WIDTH/DEPTH record type, push/full and valid/ready pop, and async active-high reset.

Test Plan:
1. Reset, then retire addi x5,x0,7 (pc 0, wb 7), then the trace_ready=1 consumer pops → one record kind 1, pc 0, addr 5, data 7; instret=1; cycle_cnt increments per clock.
2. Retire sw with mem_addr 0x40, data 0xDEAD; next cycle retire with reg_write=1, rd=0 → exactly one record, kind 2, addr 0x40, data 0xDEAD; store_cnt=1.
3. With trace_ready=0 and DEPTH=8, do 10 reg-writing retires → 8 records held, drop_cnt=2. Then pop+push on the same edge while full → record accepted, drop_cnt stays 2.
4. Retire instr 0x00000063 at pc 0x1C → halted=1, halt_cause=1 next cycle. instret and cycle_cnt freeze over 20 further cycles while retire=1. FIFO still drains.
5. Retire pc 0x200 with instr 0 and HALT_ON_ZERO=1 → cause 2, since the zero-instr check outranks the PC limit. Rerun with HALT_ON_ZERO=0 → cause 3.
6. Assert rst asynchronously mid-cycle while the FIFO holds 3 records and halted=1 → all outputs 0 immediately without waiting for a clock edge. Then repeat the same condition using clr → same state after one edge.
